dot_channel_seq: RTL and testbench
==================================

Name: dot_channel_seq

Overview:
- Sequencer for one dot channel (weight store plus 36-wide inner product).
- Walks the weight-bank select (cs) and phase indices over a programmed range. For each step it drives the weight-store and dot-channel load strobes, accepts one 36-element feature vector, waits for the channel's valid pulse, then captures and re-emits the result tagged with its indices.
- Sits between the feature-vector buffer and the layer output collector.

Parameters:
- CS_NUM, 9, number of cs values visited (1..16), cs runs 0..CS_NUM-1.
- PHASE_NUM, 8, number of phase values per cs (1..8), phase runs 0..PHASE_NUM-1.
- TIMEOUT, 31, max RUN cycles waiting for ch_valid before error (1..255).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a full cs/phase sweep; honoured only in IDLE.
- d_valid  in  1  feature buffer has a vector available.
- d_ready  out  1  one-cycle pulse: current vector is consumed.
- ws_load  out  1  weight-store load strobe to the channel.
- dc_load  out  1  dot-channel load strobe to the channel.
- cs  out  4  weight-bank select to the channel.
- phase  out  3  phase index to the channel.
- ch_valid  in  1  channel result-valid pulse.
- ch_q  in  `data_len  channel result.
- out_valid  out  1  one-cycle pulse: out_q, out_cs, out_phase are valid.
- out_q  out  `data_len  captured result.
- out_cs  out  4  cs of the captured result.
- out_phase  out  3  phase of the captured result.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at sweep end.
- err  out  1  sticky timeout flag, cleared by rst or by an accepted start.

Behaviour:
- Reset: state IDLE. All outputs 0, including cs, phase, out_q, out_cs and out_phase. Internal timer 0. Reset mid-sweep aborts immediately, with no done pulse.
- All outputs are registered.
- IDLE: on start, set cs=0, phase=0, err=0 and go to WAIT_D.
- WAIT_D: ws_load=dc_load=0. On d_valid, pulse d_ready for that cycle, clear the timer and go to RUN.
- RUN:
  - ws_load=dc_load=1 every cycle; the timer increments each cycle.
  - If ch_valid: load out_q=ch_q, out_cs=cs and out_phase=phase, pulse out_valid the next cycle, and go to GAP.
  - Else, if timer==TIMEOUT: set err and go to FIN without emitting a result.
- GAP: exactly one cycle with ws_load=dc_load=0, so the channel's internal counter and valid output clear. Then advance the indices:
  - If phase<PHASE_NUM-1: phase+1, go to WAIT_D.
  - Else if cs<CS_NUM-1: phase=0, cs+1, go to WAIT_D.
  - Else go to FIN.
- FIN: pulse done for one cycle, drop busy, return to IDLE. cs and phase hold their last values.
- Simultaneous events:
  - ch_valid in the same cycle the timer reaches TIMEOUT: ch_valid wins, and there is no err.
  - ch_valid outside RUN is ignored.
  - start outside IDLE is ignored.
  - d_valid outside WAIT_D does not produce d_ready.
- Expected step latency with a nominal channel: ws_valid one cycle after ws_load, inner count to 5, then valid. That gives ch_valid about 7 cycles after RUN entry. The full step is WAIT_D(1, when d_valid is already high) + RUN(about 7) + GAP(1).
- Total results per sweep: CS_NUM*PHASE_NUM, in order cs-major, phase-minor.

Test Plan:
- Full sweep, CS_NUM=2, PHASE_NUM=3, d_valid held high, channel model asserts ch_valid 7 cycles into RUN with ch_q=step index -> 6 out_valid pulses. Tags are (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) and out_q=0..5. Exactly one done, and err=0.
- d_valid stalled low for 10 cycles before step 2 -> ws_load and dc_load stay 0, with no d_ready, until d_valid rises. Then d_ready pulses exactly once and RUN resumes with cs=0, phase=1.
- Channel never asserts ch_valid, TIMEOUT=31 -> RUN lasts 32 cycles, err=1, done pulses once, and no out_valid. A new start clears err.
- ch_valid in the same cycle timer==TIMEOUT -> result emitted, err=0, sweep continues.
- rst asserted mid-RUN at step 4 -> the next cycle all outputs are 0 and the state is IDLE with no done. A subsequent start restarts at cs=0, phase=0.
- start pulsed while busy, and ch_valid pulsed during WAIT_D -> no change to sequence order or output count.

Source files
------------

// File: rtl/dot_channel_seq_if.sv
// Handshake and data bundle between the dot-channel sequencer, the feature
// buffer, the channel itself and the layer output collector.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

interface dot_channel_seq_if;
  logic                 d_valid;
  logic                 d_ready;
  logic                 ws_load;
  logic                 dc_load;
  logic [3:0]           cs;
  logic [2:0]           phase;
  logic                 ch_valid;
  logic [`DATA_LEN-1:0] ch_q;
  logic                 out_valid;
  logic [`DATA_LEN-1:0] out_q;
  logic [3:0]           out_cs;
  logic [2:0]           out_phase;

  modport master (
    input  d_valid, ch_valid, ch_q,
    output d_ready, ws_load, dc_load, cs, phase,
           out_valid, out_q, out_cs, out_phase
  );

  modport slave (
    output d_valid, ch_valid, ch_q,
    input  d_ready, ws_load, dc_load, cs, phase,
           out_valid, out_q, out_cs, out_phase
  );
endinterface

// File: rtl/dot_channel_seq.sv
// Sweeps cs/phase over the programmed range, feeding one feature vector per
// step into the dot channel and re-emitting each result tagged with its indices.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

// state  | meaning
// IDLE   | waiting for start
// WAIT_D | loads low, waiting for a feature vector
// RUN    | loads high, waiting for ch_valid or timeout
// GAP    | one cycle with loads low so the channel clears, then advance indices
// FIN    | done pulse, back to IDLE
module dot_channel_seq #(
  parameter int CS_NUM    = 9,
  parameter int PHASE_NUM = 8,
  parameter int TIMEOUT   = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  dot_channel_seq_if.master  bus
);

  localparam logic [3:0] CS_LAST = 4'(CS_NUM - 1);
  localparam logic [2:0] PH_LAST = 3'(PHASE_NUM - 1);
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WAIT_D, RUN, GAP, FIN} state_t;

  state_t     state;
  logic [7:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.ws_load   <= 1'b0;
      bus.dc_load   <= 1'b0;
      bus.cs        <= '0;
      bus.phase     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_q     <= '0;
      bus.out_cs    <= '0;
      bus.out_phase <= '0;
    end else begin
      bus.d_ready   <= 1'b0;
      bus.out_valid <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bus.cs    <= '0;
            bus.phase <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT_D;
          end
        end
        WAIT_D: begin
          if (bus.d_valid) begin
            bus.d_ready <= 1'b1;
            bus.ws_load <= 1'b1;
            bus.dc_load <= 1'b1;
            timer       <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          // a result arriving on the timeout cycle still counts
          if (bus.ch_valid) begin
            bus.out_q     <= bus.ch_q;
            bus.out_cs    <= bus.cs;
            bus.out_phase <= bus.phase;
            bus.out_valid <= 1'b1;
            bus.ws_load   <= 1'b0;
            bus.dc_load   <= 1'b0;
            state         <= GAP;
          end else if (timer == TO_LIM) begin
            err         <= 1'b1;
            bus.ws_load <= 1'b0;
            bus.dc_load <= 1'b0;
            done        <= 1'b1;
            state       <= FIN;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        GAP: begin
          if (bus.phase < PH_LAST) begin
            bus.phase <= bus.phase + 3'd1;
            state     <= WAIT_D;
          end else if (bus.cs < CS_LAST) begin
            bus.phase <= '0;
            bus.cs    <= bus.cs + 4'd1;
            state     <= WAIT_D;
          end else begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_channel_seq.sv
// Bench for dot_channel_seq: a behavioural channel model answers each RUN
// after a chosen delay; results are compared to the cs-major/phase-minor order.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_dot_channel_seq;
  localparam int DW    = `DATA_LEN;
  localparam int CSN   = 2;
  localparam int PHN   = 3;
  localparam int TMO   = 31;
  localparam int NSTEP = CSN * PHN;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [3:0]    cs;
    logic [2:0]    ph;
  } res_t;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, err;

  dot_channel_seq_if bus ();

  dot_channel_seq #(.CS_NUM(CSN), .PHASE_NUM(PHN), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int            delay_q[$];
  logic [DW-1:0] val_q[$];
  logic [DW-1:0] exp_val[NSTEP];
  res_t          obs_q[$];
  int            done_cnt, dready_cnt;
  bit            inj;

  // channel model: ch_valid in the Nth cycle of a load burst, stray pulses otherwise
  int            run_cnt;
  int            cur_delay;
  logic [DW-1:0] cur_val;
  initial begin
    bus.ch_valid = 1'b0;
    bus.ch_q     = '0;
    run_cnt      = 0;
    cur_delay    = 0;
    cur_val      = '0;
    forever begin
      @(negedge clk);
      if (bus.ws_load === 1'b1) begin
        run_cnt++;
        if (run_cnt == 1) begin
          cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 1000;
          cur_val   = (val_q.size() > 0) ? val_q.pop_front() : DW'($urandom);
        end
        bus.ch_valid = (run_cnt == cur_delay);
        bus.ch_q     = cur_val;
      end else begin
        run_cnt      = 0;
        bus.ch_valid = inj;
        bus.ch_q     = DW'($urandom);
      end
    end
  end

  initial begin
    res_t r;
    done_cnt   = 0;
    dready_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        r.q  = bus.out_q;
        r.cs = bus.out_cs;
        r.ph = bus.out_phase;
        obs_q.push_back(r);
      end
      if (done === 1'b1) done_cnt++;
      if (bus.d_ready === 1'b1) dready_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_env();
    delay_q.delete();
    val_q.delete();
    obs_q.delete();
    done_cnt   = 0;
    dready_cnt = 0;
    inj        = 1'b0;
  endtask

  task automatic load_steps(input int lo, input int hi);
    for (int i = 0; i < NSTEP; i++) begin
      exp_val[i] = DW'($urandom);
      delay_q.push_back($urandom_range(hi, lo));
      val_q.push_back(exp_val[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    start       = 1'b0;
    bus.d_valid = 1'b0;
    inj         = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %b want 000", {busy, done, err});
    end
    checks++;
    if ({bus.d_ready, bus.ws_load, bus.dc_load, bus.out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0000",
               {bus.d_ready, bus.ws_load, bus.dc_load, bus.out_valid});
    end
    checks++;
    if ({bus.cs, bus.phase, bus.out_q, bus.out_cs, bus.out_phase} !== '0) begin
      errors++;
      $display("FAIL reset_data: got cs=%0h ph=%0h q=%0h ocs=%0h oph=%0h want all 0",
               bus.cs, bus.phase, bus.out_q, bus.out_cs, bus.out_phase);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_sweep();
    bit to;
    clear_env();
    for (int i = 0; i < NSTEP; i++) begin
      delay_q.push_back(7);
      val_q.push_back(DW'(i));
    end
    bus.d_valid = 1'b1;
    pulse_start();
    wait_done(400, to);
    checks++;
    if (to) begin errors++; $display("FAIL sweep_done_timeout: no done within budget"); end
    checks++;
    if (obs_q.size() !== NSTEP) begin
      errors++;
      $display("FAIL sweep_count: got %0d results want %0d", obs_q.size(), NSTEP);
    end
    for (int i = 0; i < NSTEP && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {DW'(i), 4'(i / PHN), 3'(i % PHN)}) begin
        errors++;
        $display("FAIL sweep_res%0d: got q=%0h cs=%0d ph=%0d want q=%0h cs=%0d ph=%0d",
                 i, obs_q[i].q, obs_q[i].cs, obs_q[i].ph, i, i / PHN, i % PHN);
      end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL sweep_done_cnt: got %0d want 1", done_cnt); end
    checks++;
    if (dready_cnt !== NSTEP) begin
      errors++;
      $display("FAIL sweep_dready_cnt: got %0d want %0d", dready_cnt, NSTEP);
    end
    checks++;
    if ({err, busy} !== 2'b00) begin errors++; $display("FAIL sweep_err_busy: got %b want 00", {err, busy}); end
  endtask

  task automatic test_stall();
    bit to;
    int bad;
    clear_env();
    load_steps(1, 20);
    bus.d_valid = 1'b1;
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
    checks++;
    if (to) begin errors++; $display("FAIL stall_first_result: none within budget"); end
    bus.d_valid = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ({bus.ws_load, bus.dc_load, bus.d_ready} !== 3'b000) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_loads_low: got %0d bad cycles want 0", bad); end
    checks++;
    if (dready_cnt !== 1) begin errors++; $display("FAIL stall_dready_cnt: got %0d want 1", dready_cnt); end
    bus.d_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.d_ready, bus.ws_load, bus.dc_load, bus.cs, bus.phase} !== {3'b111, 4'd0, 3'd1}) begin
      errors++;
      $display("FAIL stall_resume: got rdy=%b ws=%b dc=%b cs=%0d ph=%0d want 1 1 1 0 1",
               bus.d_ready, bus.ws_load, bus.dc_load, bus.cs, bus.phase);
    end
    @(negedge clk);
    checks++;
    if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL stall_dready_pulse: got %b want 0", bus.d_ready); end
    wait_done(600, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_done_timeout: no done within budget"); end
    checks++;
    if (obs_q.size() !== NSTEP) begin
      errors++;
      $display("FAIL stall_count: got %0d results want %0d", obs_q.size(), NSTEP);
    end
    for (int i = 0; i < NSTEP && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {exp_val[i], 4'(i / PHN), 3'(i % PHN)}) begin
        errors++;
        $display("FAIL stall_res%0d: got q=%0h cs=%0d ph=%0d want q=%0h cs=%0d ph=%0d",
                 i, obs_q[i].q, obs_q[i].cs, obs_q[i].ph, exp_val[i], i / PHN, i % PHN);
      end
    end
  endtask

  task automatic test_timeout();
    bit to;
    int run_cycles;
    clear_env();
    delay_q.push_back(1000);
    bus.d_valid = 1'b1;
    pulse_start();
    run_cycles = 0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.ws_load === 1'b1) run_cycles++;
      if (done === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (to) begin errors++; $display("FAIL timeout_done: no done within budget"); end
    checks++;
    if (run_cycles !== TMO + 1) begin
      errors++;
      $display("FAIL timeout_run_len: got %0d cycles want %0d", run_cycles, TMO + 1);
    end
    checks++;
    if ({err, busy} !== 2'b10) begin errors++; $display("FAIL timeout_err: got err,busy=%b want 10", {err, busy}); end
    checks++;
    if (obs_q.size() !== 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL timeout_outputs: got results=%0d done=%0d want 0 1", obs_q.size(), done_cnt);
    end
    clear_env();
    for (int i = 0; i < NSTEP; i++) begin
      exp_val[i] = DW'($urandom);
      delay_q.push_back(7);
      val_q.push_back(exp_val[i]);
    end
    pulse_start();
    checks++;
    if ({err, busy} !== 2'b01) begin errors++; $display("FAIL timeout_err_clear: got err,busy=%b want 01", {err, busy}); end
    wait_done(400, to);
    checks++;
    if (to || obs_q.size() !== NSTEP || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resweep: got timeout=%b results=%0d err=%b want 0 %0d 0",
               to, obs_q.size(), err, NSTEP);
    end
  endtask

  task automatic test_collision();
    bit to;
    clear_env();
    load_steps(1, 31);
    delay_q[0] = TMO + 1;
    bus.d_valid = 1'b1;
    pulse_start();
    wait_done(600, to);
    checks++;
    if (to) begin errors++; $display("FAIL collide_done: no done within budget"); end
    checks++;
    if (err !== 1'b0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL collide_err: got err=%b done=%0d want 0 1", err, done_cnt);
    end
    checks++;
    if (obs_q.size() !== NSTEP) begin
      errors++;
      $display("FAIL collide_count: got %0d results want %0d", obs_q.size(), NSTEP);
    end
    for (int i = 0; i < NSTEP && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {exp_val[i], 4'(i / PHN), 3'(i % PHN)}) begin
        errors++;
        $display("FAIL collide_res%0d: got q=%0h cs=%0d ph=%0d want q=%0h cs=%0d ph=%0d",
                 i, obs_q[i].q, obs_q[i].cs, obs_q[i].ph, exp_val[i], i / PHN, i % PHN);
      end
    end
  endtask

  task automatic test_rst_mid_run();
    bit to;
    int seen;
    clear_env();
    for (int i = 0; i < NSTEP; i++) begin
      delay_q.push_back(7);
      val_q.push_back(DW'(i + 100));
    end
    bus.d_valid = 1'b1;
    pulse_start();
    seen = 0;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      if (seen == 3 && bus.ws_load === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (to) begin errors++; $display("FAIL rst_reach_step4: step 4 RUN not reached"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, bus.d_ready, bus.ws_load, bus.dc_load, bus.out_valid,
         bus.cs, bus.phase, bus.out_q, bus.out_cs, bus.out_phase} !== '0) begin
      errors++;
      $display("FAIL rst_outputs: got busy=%b ws=%b cs=%0d ph=%0d q=%0h ocs=%0d oph=%0d want all 0",
               busy, bus.ws_load, bus.cs, bus.phase, bus.out_q, bus.out_cs, bus.out_phase);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || obs_q.size() !== 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: got done=%0d results=%0d busy=%b want 0 3 0",
               done_cnt, obs_q.size(), busy);
    end
    clear_env();
    load_steps(1, 20);
    pulse_start();
    checks++;
    if ({busy, bus.cs, bus.phase} !== {1'b1, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL rst_restart_idx: got busy=%b cs=%0d ph=%0d want 1 0 0", busy, bus.cs, bus.phase);
    end
    wait_done(600, to);
    checks++;
    if (to || obs_q.size() !== NSTEP) begin
      errors++;
      $display("FAIL rst_restart_sweep: got timeout=%b results=%0d want 0 %0d", to, obs_q.size(), NSTEP);
    end
    for (int i = 0; i < NSTEP && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {exp_val[i], 4'(i / PHN), 3'(i % PHN)}) begin
        errors++;
        $display("FAIL rst_res%0d: got q=%0h cs=%0d ph=%0d want q=%0h cs=%0d ph=%0d",
                 i, obs_q[i].q, obs_q[i].cs, obs_q[i].ph, exp_val[i], i / PHN, i % PHN);
      end
    end
  endtask

  task automatic test_ignore();
    bit to;
    clear_env();
    load_steps(1, 20);
    bus.d_valid = 1'b1;
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin to = 1'b0; break; end
      bus.d_valid = 1'($urandom_range(1, 0));
      start       = (busy === 1'b1) ? ($urandom_range(3, 0) == 0) : 1'b0;
      inj         = 1'($urandom_range(1, 0));
    end
    start       = 1'b0;
    inj         = 1'b0;
    bus.d_valid = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (to) begin errors++; $display("FAIL ignore_done: no done within budget"); end
    checks++;
    if (done_cnt !== 1 || dready_cnt !== NSTEP || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_counts: got done=%0d dready=%0d err=%b busy=%b want 1 %0d 0 0",
               done_cnt, dready_cnt, err, busy, NSTEP);
    end
    checks++;
    if (obs_q.size() !== NSTEP) begin
      errors++;
      $display("FAIL ignore_count: got %0d results want %0d", obs_q.size(), NSTEP);
    end
    for (int i = 0; i < NSTEP && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {exp_val[i], 4'(i / PHN), 3'(i % PHN)}) begin
        errors++;
        $display("FAIL ignore_res%0d: got q=%0h cs=%0d ph=%0d want q=%0h cs=%0d ph=%0d",
                 i, obs_q[i].q, obs_q[i].cs, obs_q[i].ph, exp_val[i], i / PHN, i % PHN);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bus.d_valid = 1'b0;
    inj         = 1'b0;
    test_reset();
    test_full_sweep();
    test_stall();
    test_timeout();
    test_collision();
    test_rst_mid_run();
    test_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
